// File: rtl/smac_pkg.sv
// Shared types and helpers for the SMAC datapath boundary blocks.
`default_nettype none

package smac_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } ser_state_t;

  // Width of an index over n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/output_serializer_if.sv
// Load/drain bus of the output serializer: parallel capture in, one lane per beat out.
`default_nettype none

interface output_serializer_if #(
  parameter int M = 16,
  parameter int N = 4
);

  logic           ld_en;
  logic           cl_en;
  logic [N*M-1:0] inr;
  logic           out_ready;
  logic           out_valid;
  logic [M-1:0]   outr;
  logic           out_last;
  logic           busy;
  logic           overrun;

  modport master (
    output ld_en, cl_en, inr, out_ready,
    input  out_valid, outr, out_last, busy, overrun
  );

  modport slave (
    input  ld_en, cl_en, inr, out_ready,
    output out_valid, outr, out_last, busy, overrun
  );

endinterface

`default_nettype wire

// File: rtl/output_serializer.sv
// Captures N lanes of M bits on a load strobe and streams them out one lane per
// valid/ready beat; flags loads dropped while a drain is in progress.
`default_nettype none

module output_serializer
  import smac_pkg::*;
#(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output_serializer_if.slave    bus
);

  localparam int             IW       = clog2_min1(N);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

  ser_state_t            state_q, state_d;
  logic [N-1:0][M-1:0]   lanes_q, lanes_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  overrun_q, overrun_d;

  logic                  at_last;
  logic                  xfer;

  assign at_last = (idx_q == LAST_IDX);
  assign xfer    = (state_q == DRAIN) && bus.out_ready;

  // State register with lane bank and index counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lanes_q   <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lanes_q   <= lanes_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    lanes_d   = lanes_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;

    if (bus.cl_en) begin
      // Clear wins over everything, including a coincident load.
      state_d   = IDLE;
      lanes_d   = '0;
      idx_d     = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.ld_en) begin
            lanes_d = bus.inr;
            idx_d   = '0;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (xfer && at_last) begin
            idx_d = '0;
            if (bus.ld_en) begin
              // Back-to-back reload: next beat is lane 0 with no bubble.
              lanes_d = bus.inr;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (xfer) begin
              idx_d = idx_q + IW'(1);
            end
            if (bus.ld_en) begin
              overrun_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output logic: everything is decoded from registered state only
  always_comb begin
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.outr      = '0;
    bus.out_last  = 1'b0;
    bus.overrun   = overrun_q;
    if (state_q == DRAIN) begin
      bus.out_valid = 1'b1;
      bus.busy      = 1'b1;
      bus.outr      = lanes_q[idx_q];
      bus.out_last  = at_last;
    end
  end

endmodule

`default_nettype wire
